// File: rtl/seq_comparator.sv
// Bit-serial magnitude comparator: scans latched operands MSB first, one bit pair
// per cycle, and stops at the first differing bit.
module seq_comparator #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             C2,
  output logic             C1,
  output logic             C0
);

  localparam int             IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]  TOP = IW'(WIDTH - 1);
  localparam bit             SGN = (SIGNED != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             load, finish;
  logic             bit_a, bit_b;

  // Result as {C2, C1, C0}. In two's complement a 1 in the sign bit means the
  // smaller value, so a difference there flips the sense.
  function automatic logic [2:0] decide(input logic ba, input logic bb, input logic at_msb);
    logic gt;
    if (ba == bb) return 3'b100;
    gt = ba ^ (SGN & at_msb);
    return {1'b0, gt, ~gt};
  endfunction

  assign bit_a = a_q[idx];
  assign bit_b = b_q[idx];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
          load      = 1'b1;
        end
      end
      SCAN: begin
        if ((bit_a != bit_b) || (idx == '0)) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE: begin
        load      = start;
        state_nxt = start ? SCAN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      idx          <= '0;
      {C2, C1, C0} <= 3'b000;
    end else begin
      if (load) begin
        a_q <= A;
        b_q <= B;
        idx <= TOP;
      end else if (state == SCAN && !finish) begin
        idx <= idx - IW'(1);
      end
      if (finish) {C2, C1, C0} <= decide(bit_a, bit_b, idx == TOP);
    end
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule
